// File: rtl/gf_mul_seq_if.sv
// Operand/result handshake bundle for the sequential GF(2^3) multiplier.
// The producer side drives the operands and out_ready; the multiplier drives the rest.
interface gf_mul_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] a;
  logic [2:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] p;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/gf_mul_seq.sv
// Sequential GF(2^3) multiplier: MSB-first shift-and-add over three RUN cycles,
// result held in DONE until the consumer takes it.
module gf_mul_seq #(
  parameter logic [2:0] POLY = 3'b011
) (
  input  logic         Clk,
  input  logic         nRst,
  gf_mul_seq_if.slave  bus,
  output logic         busy,
  output logic [7:0]   op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] a_reg, b_reg, acc;
  logic [1:0] bit_idx;
  logic       accept, deliver;
  logic [2:0] acc_shift, acc_step;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values, independent of the order the processes are evaluated.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    accept        = 1'b0;
    deliver       = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bit_idx == 2'd0) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Multiply-by-x with reduction, then conditionally add the multiplicand.
  always_comb begin
    acc_shift = {acc[1:0], 1'b0} ^ (acc[2] ? POLY : 3'b000);
    acc_step  = acc_shift ^ (b_reg[bit_idx] ? a_reg : 3'b000);
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      a_reg   <= 3'b000;
      b_reg   <= 3'b000;
      acc     <= 3'b000;
      bit_idx <= 2'd2;
      op_cnt  <= 8'd0;
    end else begin
      if (accept) begin
        a_reg   <= bus.a;
        b_reg   <= bus.b;
        acc     <= 3'b000;
        bit_idx <= 2'd2;
      end else if (state == RUN) begin
        acc     <= acc_step;
        bit_idx <= bit_idx - 2'd1;
      end
      if (deliver) op_cnt <= op_cnt + 8'd1;
    end
  end

  // The accumulator is only written in RUN or on accept, so p is stable in DONE.
  assign bus.p = acc;

endmodule

// File: tb/tb_gf_mul_seq.sv
// Directed self-checking bench for gf_mul_seq: products, backpressure,
// mid-operation reset, exhaustive operand sweep and counter wrap.
module tb_gf_mul_seq;

  logic       Clk;
  logic       nRst;
  logic       busy;
  logic [7:0] op_cnt;
  int         checks;
  int         errors;

  gf_mul_seq_if bus ();

  gf_mul_seq #(.POLY(3'b011)) dut (
    .Clk    (Clk),
    .nRst   (nRst),
    .bus    (bus.slave),
    .busy   (busy),
    .op_cnt (op_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Carry-less product to 5 bits, then reduce by x^3 + x + 1.
  function automatic logic [2:0] gf_ref(input logic [2:0] x, input logic [2:0] y);
    logic [4:0] prod;
    prod = 5'b0;
    for (int k = 0; k < 3; k++)
      if (y[k]) prod = prod ^ (5'({2'b00, x}) << k);
    for (int k = 4; k >= 3; k--)
      if (prod[k]) prod = prod ^ (5'b01011 << (k - 3));
    return prod[2:0];
  endfunction

  task automatic do_reset();
    nRst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1 nRst = 1'b1;
  endtask

  // Called at #1 after the accepting edge; waits for the result and hands it off.
  task automatic finish_op(input logic [2:0] exp, input string tag);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 10) begin
      @(posedge Clk);
      #1 lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_p"}, 32'(bus.p), 32'(exp));
    @(posedge Clk);
    #1;
    check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [2:0] ta, input logic [2:0] tbv,
                        input logic [2:0] exp, input string tag);
    bus.a = ta;
    bus.b = tbv;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = ~ta;
    bus.b = ~tbv;
    finish_op(exp, tag);
  endtask

  initial begin
    int         lat;
    logic [7:0] v;
    checks = 0;
    errors = 0;
    nRst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = 3'b000;
    bus.b = 3'b000;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_p", 32'(bus.p), 32'd0);
    check("rst_op_cnt", 32'(op_cnt), 32'd0);
    @(posedge Clk);
    #1 nRst = 1'b1;
    #1 check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic product
    run_op(3'b010, 3'b100, 3'b011, "basic");
    check("basic_op_cnt", 32'(op_cnt), 32'd1);

    // Back-to-back sequence
    do_reset();
    run_op(3'b111, 3'b111, 3'b011, "seq0");
    run_op(3'b101, 3'b011, 3'b100, "seq1");
    run_op(3'b110, 3'b001, 3'b110, "seq2");
    run_op(3'b000, 3'b101, 3'b000, "seq3");
    check("seq_op_cnt", 32'(op_cnt), 32'd4);

    // Backpressure: hold DONE while offering a competing operand pair
    do_reset();
    bus.a = 3'b011;
    bus.b = 3'b101;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge Clk);
    #1;
    bus.a = 3'b111;
    bus.b = 3'b111;
    lat = 0;
    while (!bus.out_valid && lat < 10) begin
      @(posedge Clk);
      #1 lat++;
    end
    check("bp_lat", 32'(lat), 32'd3);
    check("bp_p0", 32'(bus.p), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      #1;
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_p", 32'(bus.p), 32'd4);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    check("bp_cnt_hold", 32'(op_cnt), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge Clk);
    #1;
    check("bp_rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_rel_busy", 32'(busy), 32'd0);
    check("bp_rel_valid", 32'(bus.out_valid), 32'd0);
    check("bp_rel_cnt", 32'(op_cnt), 32'd1);
    @(posedge Clk);
    #1 check("bp_cnt_once", 32'(op_cnt), 32'd1);

    // Mid-operation reset during the second RUN cycle
    bus.a = 3'b111;
    bus.b = 3'b111;
    bus.in_valid = 1'b1;
    @(posedge Clk);
    #1 bus.in_valid = 1'b0;
    @(posedge Clk);
    #1 nRst = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_valid", 32'(bus.out_valid), 32'd0);
    check("mid_p", 32'(bus.p), 32'd0);
    check("mid_op_cnt", 32'(op_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1 check("mid_no_valid", 32'(bus.out_valid), 32'd0);
    end
    // Operand presented while reset is released is taken on the very next edge
    bus.a = 3'b010;
    bus.b = 3'b100;
    bus.in_valid = 1'b1;
    nRst = 1'b1;
    #1 check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    check("post_rst_busy", 32'(busy), 32'd1);
    finish_op(3'b011, "post_rst");
    check("post_rst_cnt", 32'(op_cnt), 32'd1);

    // Exhaustive sweep against the reference model
    do_reset();
    for (int i = 0; i < 64; i++) begin
      v = 8'(i);
      run_op(v[2:0], v[5:3], gf_ref(v[2:0], v[5:3]), "exh");
    end
    check("exh_op_cnt", 32'(op_cnt), 32'd64);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      if (i == 255) check("wrap_255", 32'(op_cnt), 32'd255);
      run_op(v[5:3], v[2:0], gf_ref(v[5:3], v[2:0]), "wrap");
    end
    check("wrap_0", 32'(op_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf_mul_seq.md
GF_MUL_SEQ -- requirements
Module: gf_mul_seq

Interface
REQ-001 SHALL have parameter POLY, default 3'b011, giving the low 3 bits of the GF(2^3) field polynomial (x^3 + x + 1 by default).
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port nRst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operand pair a/b is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept an operand pair.
REQ-006 SHALL have port a, input, 3 bits: multiplicand in GF(2^3).
REQ-007 SHALL have port b, input, 3 bits: multiplier in GF(2^3).
REQ-008 SHALL have port out_valid, output, 1 bit: product p is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts p.
REQ-010 SHALL have port p, output, 3 bits: product a*b mod the field polynomial.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port op_cnt, output, 8 bits: count of products delivered.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready high only in IDLE.
REQ-015 SHALL accept operands on the rising edge where in_valid and in_ready are both high; a and b are captured into internal registers and the accumulator is cleared; the FSM goes IDLE->RUN.
REQ-016 SHALL ignore a and b at all other times; changes to a or b after acceptance do not affect the result.
REQ-017 SHALL perform one MSB-first shift-and-add step per RUN cycle using bit index i = 2, 1, 0.
REQ-018 SHALL compute each RUN step as: acc' = {acc[1:0],0} XOR (acc[2] ? POLY : 0), then acc' XOR= (b_reg[i] ? a_reg : 0).
REQ-019 SHALL remain in RUN for exactly 3 cycles, then go RUN->DONE.
REQ-020 SHALL assert out_valid only in DONE, first on the 3rd edge after acceptance (latency 3 cycles).
REQ-021 SHALL hold p equal to the accumulator, stable throughout DONE until the output handshake completes.
REQ-022 SHALL complete the output handshake on the edge where out_valid and out_ready are both high, then go DONE->IDLE and increment op_cnt modulo 256 (255 wraps to 0).
REQ-023 SHALL hold in DONE indefinitely while out_ready is low (backpressure); no new operand is accepted during that time.
REQ-024 SHALL sustain a best-case throughput of one product per 5 cycles: accept, 3 RUN cycles, DONE with out_ready high, then back in IDLE.
REQ-025 SHALL treat out_ready outside DONE and in_valid outside IDLE as don't-care, with no state change.
REQ-026 SHALL make a zero operand produce p = 0 after the same 3-cycle latency; there is no early exit.

Reset
REQ-027 SHALL, on nRst low, immediately force: FSM to IDLE, a_reg/b_reg/acc/p to 0, op_cnt to 0, out_valid 0, busy 0, and in_ready 1 once nRst is released.
REQ-028 SHALL abort any RUN or DONE operation in progress when reset is asserted mid-operation; the aborted product is never delivered and op_cnt is not incremented.
REQ-029 SHALL accept operands on the first rising edge after nRst deasserts if in_valid is high.

Verification
REQ-030 SHALL pass a basic product check: a=010, b=100, out_ready=1 -> out_valid high 3 cycles after accept, p=011, op_cnt=1.
REQ-031 SHALL pass a sequence of products with out_ready held high: a=111,b=111 -> p=011; a=101,b=011 -> p=100; a=110,b=001 -> p=110; a=000,b=101 -> p=000; op_cnt=4.
REQ-032 SHALL pass a backpressure check: out_ready held low for 10 cycles in DONE -> p and out_valid stable, in_ready low; raise out_ready -> IDLE next edge, op_cnt increments once.
REQ-033 SHALL pass a mid-operation reset check: pulse nRst low during the 2nd RUN cycle -> all outputs at reset values, no out_valid pulse, op_cnt=0.
REQ-034 SHALL pass an exhaustive check: all 64 (a,b) pairs compared against a reference model with POLY=011 -> zero mismatches, op_cnt=64.
REQ-035 SHALL pass a counter wrap check: 256 consecutive products -> op_cnt wraps from 255 to 0.
